// File: rtl/encap_min_frame_padder.sv
// Egress padder: extends AXI-Stream frames shorter than MIN_FRAME_BYTES with zero bytes.
// Frames at or above the minimum pass through unchanged behind one output register.
module encap_min_frame_padder #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  parameter int MIN_FRAME_BYTES = 60,
  localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
  localparam int EFF_ID_WIDTH   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int EFF_DEST_WIDTH = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [EFF_ID_WIDTH-1:0]   axis_in_tid,
  input  logic [EFF_DEST_WIDTH-1:0] axis_in_tdest,
  input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [EFF_ID_WIDTH-1:0]   axis_out_tid,
  output logic [EFF_DEST_WIDTH-1:0] axis_out_tdest,
  output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [31:0]               frames_padded,
  output logic                      dbg_state
);

  // A beat transfers on a cycle where valid and ready are both high at the rising
  // edge; valid, once raised, holds its payload stable until ready is seen.

  localparam int CNT_W = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] NB_C  = CNT_W'(NUM_BUS_BYTES);

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          byte_cnt;
  logic [CNT_W-1:0]          rem;
  logic                      load;
  logic                      accept;
  logic [CNT_W-1:0]          beat_bytes;
  logic [CNT_W-1:0]          need;
  logic [CNT_W:0]            sum;
  logic [AXIS_BUS_WIDTH-1:0] masked_data;

  function automatic logic [NUM_BUS_BYTES-1:0] low_keep(input logic [CNT_W-1:0] k);
    logic [NUM_BUS_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_BUS_BYTES; i++) m[i] = (CNT_W'(i) < k);
    return m;
  endfunction

  assign load           = !axis_out_tvalid || axis_out_tready;
  assign axis_in_tready = aresetn && (state == PASS) && load;
  assign accept         = axis_in_tvalid && axis_in_tready;
  assign dbg_state      = state;

  always_comb begin
    beat_bytes  = '0;
    masked_data = '0;
    for (int i = 0; i < NUM_BUS_BYTES; i++) begin
      beat_bytes = beat_bytes + CNT_W'(axis_in_tkeep[i]);
      masked_data[i*8 +: 8] = axis_in_tkeep[i] ? axis_in_tdata[i*8 +: 8] : 8'h00;
    end
    sum  = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    need = MIN_C - byte_cnt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= PASS;
      byte_cnt        <= '0;
      rem             <= '0;
      axis_out_tdata  <= '0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      frames_padded   <= '0;
    end else begin
      case (state)
        PASS: begin
          if (accept) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tid    <= axis_in_tid;
            axis_out_tdest  <= axis_in_tdest;
            if (!axis_in_tlast) begin
              axis_out_tdata <= axis_in_tdata;
              axis_out_tkeep <= axis_in_tkeep;
              axis_out_tlast <= 1'b0;
              byte_cnt       <= (sum >= {1'b0, MIN_C}) ? MIN_C : sum[CNT_W-1:0];
            end else if (sum >= {1'b0, MIN_C}) begin
              axis_out_tdata <= axis_in_tdata;
              axis_out_tkeep <= axis_in_tkeep;
              axis_out_tlast <= 1'b1;
              byte_cnt       <= '0;
            end else begin
              // Short frame: the last beat is widened to cover the first padding bytes.
              axis_out_tdata <= masked_data;
              byte_cnt       <= '0;
              if (frames_padded != 32'hFFFF_FFFF) frames_padded <= frames_padded + 32'd1;
              if (need <= NB_C) begin
                axis_out_tkeep <= low_keep(need);
                axis_out_tlast <= 1'b1;
              end else begin
                axis_out_tkeep <= '1;
                axis_out_tlast <= 1'b0;
                rem            <= need - NB_C;
                state          <= PAD;
              end
            end
          end else if (load) begin
            axis_out_tvalid <= 1'b0;
          end
        end
        PAD: begin
          // tid/tdest are left as loaded from the frame's last input beat.
          if (load) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tdata  <= '0;
            if (rem > NB_C) begin
              axis_out_tkeep <= '1;
              axis_out_tlast <= 1'b0;
              rem            <= rem - NB_C;
            end else begin
              axis_out_tkeep <= low_keep(rem);
              axis_out_tlast <= 1'b1;
              rem            <= '0;
              state          <= PASS;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_encap_min_frame_padder.sv
// Bench for encap_min_frame_padder: byte-stream reference model, per-cycle output
// compare with stall-stability checks, and directed frames with literal expectations.
module tb_encap_min_frame_padder;

  localparam int BW  = 64;
  localparam int NB  = BW / 8;
  localparam int IDW = 4;
  localparam int DW  = 1;
  localparam int MIN = 60;
  localparam int W   = 1 + IDW + DW + NB + BW;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [BW-1:0]  in_tdata = '0;
  logic [IDW-1:0] in_tid = '0;
  logic [DW-1:0]  in_tdest = '0;
  logic [NB-1:0]  in_tkeep = '0;
  logic           in_tlast = 1'b0;
  logic           in_tvalid = 1'b0;
  logic           in_tready;
  logic [BW-1:0]  out_tdata;
  logic [IDW-1:0] out_tid;
  logic [DW-1:0]  out_tdest;
  logic [NB-1:0]  out_tkeep;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready = 1'b1;
  logic [31:0]    frames_padded;
  logic           dbg_state;

  logic           rdy_mode = 1'b0;
  int             cyc_cnt = 0;
  int             checks = 0;
  int             errors = 0;

  logic [W-1:0]   exp_q[$];
  logic [BW-1:0]  f_data[$];
  logic [NB-1:0]  f_keep[$];

  encap_min_frame_padder #(
    .AXIS_BUS_WIDTH(BW), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(0), .MIN_FRAME_BYTES(MIN)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(in_tdata), .axis_in_tid(in_tid), .axis_in_tdest(in_tdest),
    .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast), .axis_in_tvalid(in_tvalid),
    .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tid(out_tid), .axis_out_tdest(out_tdest),
    .axis_out_tkeep(out_tkeep), .axis_out_tlast(out_tlast), .axis_out_tvalid(out_tvalid),
    .axis_out_tready(out_tready),
    .frames_padded(frames_padded), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge aclk) begin
    #1;
    out_tready = rdy_mode ? ~out_tready : 1'b1;
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Reference model: a short frame is its byte stream plus zeros up to MIN, re-chopped
  // into full beats; padding beats carry the frame's tid/tdest.
  task automatic model_frame(input logic [IDW-1:0] tid, input logic [DW-1:0] td,
                             output int nout, output int nbytes);
    logic [7:0]    bs[$];
    logic [BW-1:0] d;
    logic [NB-1:0] k;
    int            n;
    n = f_data.size();
    nout = 0;
    nbytes = 0;
    for (int b = 0; b < n; b++)
      for (int l = 0; l < NB; l++)
        if (f_keep[b][l]) bs.push_back(f_data[b][l*8 +: 8]);
    if (bs.size() >= MIN) begin
      for (int b = 0; b < n; b++) begin
        exp_q.push_back({(b == n - 1), tid, td, f_keep[b], f_data[b]});
        nout++;
      end
      nbytes = bs.size();
    end else begin
      while (bs.size() < MIN) bs.push_back(8'h00);
      for (int off = 0; off < MIN; off += NB) begin
        d = '0;
        k = '0;
        for (int l = 0; l < NB; l++)
          if (off + l < MIN) begin
            d[l*8 +: 8] = bs[off + l];
            k[l] = 1'b1;
            nbytes++;
          end
        exp_q.push_back({(off + NB >= MIN), tid, td, k, d});
        nout++;
      end
    end
  endtask

  task automatic add_beat(input logic [BW-1:0] d, input logic [NB-1:0] k);
    f_data.push_back(d);
    f_keep.push_back(k);
  endtask

  function automatic logic [BW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  // driver task: presents f_data/f_keep as one frame, one beat per handshake
  task automatic send_frame(input logic [IDW-1:0] tid, input logic [DW-1:0] td,
                            input bit chk_lat, input int want_beats, input int want_bytes,
                            output int cyc);
    int nout, nbytes, start, t, n;
    model_frame(tid, td, nout, nbytes);
    check_eq("model_beats", 64'(nout), 64'(want_beats));
    check_eq("model_bytes", 64'(nbytes), 64'(want_bytes));
    n = f_data.size();
    start = cyc_cnt;
    for (int b = 0; b < n; b++) begin
      in_tdata  = f_data[b];
      in_tkeep  = f_keep[b];
      in_tlast  = (b == n - 1);
      in_tid    = tid;
      in_tdest  = td;
      in_tvalid = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!in_tready && t < 1000) begin
        @(negedge aclk);
        t++;
      end
      if (t >= 1000) begin
        errors++;
        $display("FAIL in_handshake_timeout: got tready=0, required 1 within 1000 cycles");
      end
      @(posedge aclk);
      #1;
      if (chk_lat && b == 0) begin
        check_eq("latency_valid", 64'(out_tvalid), 64'd1);
        check_eq("latency_data", out_tdata, f_data[0]);
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    cyc = cyc_cnt - start;
    f_data.delete();
    f_keep.delete();
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check_eq(name, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: compares every accepted output beat and checks stalled beats stay put
  task automatic compare_loop();
    logic [W-1:0] cur, want, hold_w;
    bit hold_v;
    hold_v = 1'b0;
    hold_w = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        hold_v = 1'b0;
      end else begin
        cur = {out_tlast, out_tid, out_tdest, out_tkeep, out_tdata};
        if (hold_v) begin
          checks++;
          if (!out_tvalid || cur !== hold_w) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b word=%h, required valid=1 word=%h",
                     out_tvalid, cur, hold_w);
          end
        end
        if (out_tvalid && out_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got word=%h, required no beat", cur);
          end else begin
            want = exp_q.pop_front();
            if (cur !== want) begin
              errors++;
              $display("FAIL out_beat: got %h, required %h", cur, want);
            end
          end
          hold_v = 1'b0;
        end else if (out_tvalid) begin
          hold_v = 1'b1;
          hold_w = cur;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int cyc, cnt;
    fork
      compare_loop();
    join_none

    // reset values
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_in_tready", 64'(in_tready), 64'd0);
    check_eq("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check_eq("rst_out_tlast", 64'(out_tlast), 64'd0);
    check_eq("rst_out_tdata", out_tdata, 64'd0);
    check_eq("rst_out_tkeep", 64'(out_tkeep), 64'd0);
    check_eq("rst_frames_padded", 64'(frames_padded), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check_eq("idle_in_tready", 64'(in_tready), 64'd1);

    // 64-byte frame: unchanged, 1-cycle latency, full throughput
    for (int b = 0; b < 8; b++) add_beat(rnd_data(), 8'hFF);
    send_frame(4'd2, 1'b0, 1'b1, 8, 64, cyc);
    check_eq("full_rate_cycles", 64'(cyc), 64'd8);
    wait_drain("drain_64");
    check_eq("fp_after_64", 64'(frames_padded), 64'd0);

    // exactly 60 bytes: upper lanes of the last beat pass untouched
    for (int b = 0; b < 7; b++) add_beat(rnd_data(), 8'hFF);
    add_beat(rnd_data(), 8'h0F);
    send_frame(4'd5, 1'b1, 1'b0, 8, 60, cyc);
    wait_drain("drain_60");
    check_eq("fp_after_60", 64'(frames_padded), 64'd0);

    // 14-byte frame with stale bytes in lanes 6-7
    add_beat(rnd_data(), 8'hFF);
    add_beat({16'hAAAA, 48'h0605_0403_0201}, 8'h3F);
    send_frame(4'd1, 1'b0, 1'b0, 8, 60, cyc);
    wait_drain("drain_14");
    check_eq("fp_after_14", 64'(frames_padded), 64'd1);

    // 1-byte frame: input held off for all 7 PAD cycles
    add_beat(64'h0000_0000_0000_00C3, 8'h01);
    send_frame(4'd3, 1'b1, 1'b0, 8, 60, cyc);
    cnt = 0;
    while (!in_tready && cnt < 100) begin
      cnt++;
      @(posedge aclk);
      #1;
    end
    check_eq("pad_stall_cycles", 64'(cnt), 64'd7);
    wait_drain("drain_1");
    check_eq("fp_after_1", 64'(frames_padded), 64'd2);

    // 20-byte frame with output ready toggling every cycle
    rdy_mode = 1'b1;
    add_beat(rnd_data(), 8'hFF);
    add_beat(rnd_data(), 8'hFF);
    add_beat(rnd_data(), 8'h0F);
    send_frame(4'd7, 1'b1, 1'b0, 8, 60, cyc);
    wait_drain("drain_toggle");
    rdy_mode = 1'b0;
    @(posedge aclk);
    #1;
    check_eq("fp_after_toggle", 64'(frames_padded), 64'd3);

    // 59 bytes: one byte short, padded within the last beat; then a 64-byte frame back-to-back
    for (int b = 0; b < 7; b++) add_beat(rnd_data(), 8'hFF);
    add_beat(rnd_data(), 8'h07);
    send_frame(4'd9, 1'b0, 1'b0, 8, 60, cyc);
    for (int b = 0; b < 8; b++) add_beat(rnd_data(), 8'hFF);
    send_frame(4'd10, 1'b1, 1'b0, 8, 64, cyc);
    check_eq("b2b_cycles", 64'(cyc), 64'd8);
    wait_drain("drain_59");
    check_eq("fp_after_59", 64'(frames_padded), 64'd4);

    // reset during the 3rd PAD beat
    add_beat(64'h0000_0000_0000_0011, 8'h01);
    send_frame(4'd3, 1'b1, 1'b0, 8, 60, cyc);
    repeat (3) @(posedge aclk);
    #1;
    check_eq("pad3_state", 64'(dbg_state), 64'd1);
    check_eq("pad3_keep", 64'(out_tkeep), 64'hFF);
    check_eq("pad3_data", out_tdata, 64'd0);
    check_eq("pad3_tid", 64'(out_tid), 64'd3);
    check_eq("pad3_pending", 64'(exp_q.size()), 64'd5);
    aresetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_tvalid), 64'd0);
    check_eq("mid_rst_last", 64'(out_tlast), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state), 64'd0);
    check_eq("mid_rst_fp", 64'(frames_padded), 64'd0);
    check_eq("mid_rst_in_tready", 64'(in_tready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int b = 0; b < 8; b++) add_beat(rnd_data(), 8'hFF);
    send_frame(4'd4, 1'b0, 1'b0, 8, 64, cyc);
    wait_drain("drain_post_rst");
    check_eq("fp_post_rst", 64'(frames_padded), 64'd0);

    repeat (4) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encap_min_frame_padder.md
# encap_min_frame_padder

Egress stage placed directly downstream of the encapsulator in the full NMU transmit path. It pads any AXI-Stream frame shorter than the Ethernet minimum (default 60 bytes, excluding FCS) with zero bytes, so that decapsulated or short encapsulated frames leave the NMU MAC-legal. Frames at or above the minimum pass through unchanged behind a single output register stage. tid/tdest are carried through, and padding beats inherit them from the frame's last input beat.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits; power of two, 64..512
- AXIS_ID_WIDTH, 4, tid width; effective width max(1, value)
- AXIS_DEST_WIDTH, 0, tdest width; effective width max(1, value)
- MIN_FRAME_BYTES, 60, minimum output frame length in bytes; must be > NUM_BUS_BYTES

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- axis_in_tdata  in  AXIS_BUS_WIDTH  frame data from encapsulator
- axis_in_tid  in  EFF_ID_WIDTH  source id
- axis_in_tdest  in  EFF_DEST_WIDTH  destination
- axis_in_tkeep  in  AXIS_BUS_WIDTH/8  byte enables; low-justified and contiguous
- axis_in_tlast  in  1  end of frame
- axis_in_tvalid  in  1  beat valid
- axis_in_tready  out  1  beat accepted
- axis_out_tdata / tid / tdest / tkeep / tlast / tvalid  out  same widths as input  padded stream
- axis_out_tready  in  1  downstream ready
- frames_padded  out  32  count of frames that needed padding; saturates at 0xFFFFFFFF

## Operation
- Two-state FSM: PASS and PAD.
- byte_cnt counts bytes accepted in the current frame. It saturates at MIN_FRAME_BYTES and clears on an accepted tlast. The counter width is clog2(MIN_FRAME_BYTES+1).
- Beat size is popcount(tkeep). Non-compliant tkeep is not checked.
- PASS, non-last beat: copy the beat to the output register unchanged.
- PASS, last beat, with n = byte_cnt + popcount(tkeep) ≥ MIN: copy the beat unchanged.
- PASS, last beat, with n < MIN: zero every byte lane whose tkeep is 0, then let need = MIN − byte_cnt.
  - If need ≤ NUM_BUS_BYTES: tkeep = low `need` bytes set, tlast = 1. Stay in PASS.
  - Otherwise: tkeep = all ones, tlast = 0, rem = need − NUM_BUS_BYTES. Go to PAD.
  - Either way, increment frames_padded.
- PAD: each output beat has tdata = 0 and tid/tdest latched from the last input beat.
  - If rem > NUM_BUS_BYTES: tkeep = all ones, tlast = 0, rem −= NUM_BUS_BYTES.
  - Otherwise: tkeep = low `rem` bytes, tlast = 1, go to PASS.
- axis_in_tready = (state == PASS) && (!axis_out_tvalid || axis_out_tready). Input is held off for the whole PAD state.
- Output register loads whenever it is empty or axis_out_tready is high. Contents stay stable while tvalid=1 and tready=0.

## Timing
- Reset values: axis_out_tvalid 0, axis_out_tlast 0, tdata/tkeep/tid/tdest 0, frames_padded 0, state PASS, byte_cnt 0, rem 0. axis_in_tready is 0 during reset.
- Reset asserted mid-frame or mid-PAD discards the partial frame and returns to PASS immediately. No stray tlast is emitted.
- Latency is 1 cycle from input handshake to axis_out_tvalid.
- Full throughput (one beat/cycle) in PASS when axis_out_tready is held high.
- Cost of a short frame: ceil((MIN − bytes rounded up to a full beat) / NUM_BUS_BYTES) extra cycles, with input stalled.
- First PAD beat is presented the cycle after the short last beat is accepted, if the output register drains.
- Simultaneous output drain and input accept in the same cycle is legal; no bubble.
- Back-to-back frames: a new frame's first beat may be accepted the cycle after the final PAD beat loads.

## Test plan
- 64-byte frame (8 beats, last tkeep 0xFF), tready always 1 → identical 8 beats out, 1-cycle latency, frames_padded stays 0.
- Exactly 60 bytes (7×0xFF, last 0x0F) → passed unchanged, frames_padded 0.
- 14-byte frame: beats 0xFF, then 0x3F with lanes 6–7 = 0xAA → 8 output beats.
  - Beat 1: tkeep 0xFF, lanes 6–7 = 0x00.
  - Then 5 zero beats with tkeep 0xFF.
  - Final zero beat with tkeep 0x0F, tlast = 1.
  - Total 60 bytes; frames_padded = 1.
- 1-byte frame, tkeep 0x01, tid = 3, tdest = 1 → 8 beats totalling 60 bytes, all carrying tid 3 / tdest 1. axis_in_tready = 0 for the 7 PAD cycles.
- Short frame with axis_out_tready toggling 1/0 every cycle during PAD → each beat held stable while stalled; byte totals still 60; no duplicated or dropped beat.
- aresetn pulsed low during the 3rd PAD beat → outputs reset values immediately. The next 64-byte frame passes unchanged with correct tlast.
